// File: rtl/dijkstra_mem_bridge.sv
// Bridges a level-handshake core memory port onto Avalon-MM with a stall timeout.
// Ports: algorithm_clock/reset, core_* request side, avm_* master side, busy,
// timeout_error/clear_error. Optional macro DIJKSTRA_MEM_BRIDGE_HIT_CACHE_EN
// adds a one-entry read cache that answers repeated reads without Avalon access.
module dijkstra_mem_bridge #(
  parameter int MADDR_WIDTH   = 32,
  parameter int MDATA_WIDTH   = 16,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                   algorithm_clock,
  input  logic                   algorithm_reset,
  input  logic                   core_read_enable,
  input  logic                   core_write_enable,
  input  logic [MADDR_WIDTH-1:0] core_addr,
  input  logic [MDATA_WIDTH-1:0] core_write_data,
  output logic [MDATA_WIDTH-1:0] core_read_data,
  output logic                   core_read_ready,
  output logic                   core_write_ready,
  output logic [MADDR_WIDTH-1:0] avm_address,
  output logic                   avm_read,
  output logic                   avm_write,
  output logic [MDATA_WIDTH-1:0] avm_writedata,
  input  logic [MDATA_WIDTH-1:0] avm_readdata,
  input  logic                   avm_readdatavalid,
  input  logic                   avm_waitrequest,
  output logic                   busy,
  output logic                   timeout_error,
  input  logic                   clear_error
);

  typedef enum logic [2:0] {
    IDLE, RD_CMD, RD_DATA, WR_CMD, RESP
  } state_t;

  // Abort on the edge where the stall count would reach all ones.
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST =
    {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

  state_t                   r_state;
  logic [TIMEOUT_WIDTH-1:0] r_cnt;
  logic                     r_avm_read;
  logic                     r_avm_write;
  logic [MADDR_WIDTH-1:0]   r_addr;
  logic [MDATA_WIDTH-1:0]   r_wdata;
  logic [MDATA_WIDTH-1:0]   r_rdata;
  logic                     r_rd_rdy;
  logic                     r_wr_rdy;
  logic                     r_err;
  logic                     w_last;

`ifdef DIJKSTRA_MEM_BRIDGE_HIT_CACHE_EN
  logic                     r_c_vld;
  logic [MADDR_WIDTH-1:0]   r_c_tag;
  logic [MDATA_WIDTH-1:0]   r_c_data;
`endif

  assign w_last = (r_cnt >= CNT_LAST);

  always_ff @(posedge algorithm_clock or negedge algorithm_reset) begin
    if (!algorithm_reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_avm_read  <= 1'b0;
      r_avm_write <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_rd_rdy    <= 1'b0;
      r_wr_rdy    <= 1'b0;
      r_err       <= 1'b0;
`ifdef DIJKSTRA_MEM_BRIDGE_HIT_CACHE_EN
      r_c_vld     <= 1'b0;
      r_c_tag     <= '0;
      r_c_data    <= '0;
`endif
    end else begin
      r_rd_rdy <= 1'b0;
      r_wr_rdy <= 1'b0;
      // A timeout set below overrides this clear in the same cycle.
      if (clear_error) r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (core_read_enable) begin
            r_addr <= core_addr;
`ifdef DIJKSTRA_MEM_BRIDGE_HIT_CACHE_EN
            if (r_c_vld && r_c_tag == core_addr) begin
              r_rdata  <= r_c_data;
              r_rd_rdy <= 1'b1;
              r_state  <= RESP;
            end else begin
              r_avm_read <= 1'b1;
              r_cnt      <= '0;
              r_state    <= RD_CMD;
            end
`else
            r_avm_read <= 1'b1;
            r_cnt      <= '0;
            r_state    <= RD_CMD;
`endif
          end else if (core_write_enable) begin
            r_addr      <= core_addr;
            r_wdata     <= core_write_data;
            r_avm_write <= 1'b1;
            r_cnt       <= '0;
            r_state     <= WR_CMD;
`ifdef DIJKSTRA_MEM_BRIDGE_HIT_CACHE_EN
            if (r_c_vld && r_c_tag == core_addr)
              r_c_data <= core_write_data;
`endif
          end
        end
        RD_CMD: begin
          r_cnt <= r_cnt + 1'b1;
          if (!avm_waitrequest) begin
            r_avm_read <= 1'b0;
            r_state    <= RD_DATA;
          end else if (w_last) begin
            r_avm_read <= 1'b0;
            r_rdata    <= '1;
            r_err      <= 1'b1;
            r_rd_rdy   <= 1'b1;
            r_state    <= RESP;
`ifdef DIJKSTRA_MEM_BRIDGE_HIT_CACHE_EN
            r_c_vld    <= 1'b0;
`endif
          end
        end
        RD_DATA: begin
          r_cnt <= r_cnt + 1'b1;
          if (avm_readdatavalid) begin
            r_rdata  <= avm_readdata;
            r_rd_rdy <= 1'b1;
            r_state  <= RESP;
`ifdef DIJKSTRA_MEM_BRIDGE_HIT_CACHE_EN
            r_c_vld  <= 1'b1;
            r_c_tag  <= r_addr;
            r_c_data <= avm_readdata;
`endif
          end else if (w_last) begin
            r_rdata  <= '1;
            r_err    <= 1'b1;
            r_rd_rdy <= 1'b1;
            r_state  <= RESP;
`ifdef DIJKSTRA_MEM_BRIDGE_HIT_CACHE_EN
            r_c_vld  <= 1'b0;
`endif
          end
        end
        WR_CMD: begin
          r_cnt <= r_cnt + 1'b1;
          if (!avm_waitrequest) begin
            r_avm_write <= 1'b0;
            r_wr_rdy    <= 1'b1;
            r_state     <= RESP;
          end else if (w_last) begin
            r_avm_write <= 1'b0;
            r_err       <= 1'b1;
            r_wr_rdy    <= 1'b1;
            r_state     <= RESP;
`ifdef DIJKSTRA_MEM_BRIDGE_HIT_CACHE_EN
            r_c_vld     <= 1'b0;
`endif
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign core_read_data   = r_rdata;
  assign core_read_ready  = r_rd_rdy;
  assign core_write_ready = r_wr_rdy;
  assign avm_address      = r_addr;
  assign avm_read         = r_avm_read;
  assign avm_write        = r_avm_write;
  assign avm_writedata    = r_wdata;
  assign busy             = (r_state != IDLE);
  assign timeout_error    = r_err;

endmodule

// File: tb/tb_dijkstra_mem_bridge.sv
// Self-checking bench for dijkstra_mem_bridge: directed and random transactions
// against a transaction-level latency/cache model; TIMEOUT_WIDTH is 4.
module tb_dijkstra_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cre = 1'b0, cwe = 1'b0, clr = 1'b0;
  logic [31:0] caddr = '0;
  logic [15:0] cwdata = '0;
  logic [15:0] crdata;
  logic        crrdy, cwrdy;
  logic [31:0] aaddr;
  logic        aread, awrite;
  logic [15:0] awdata;
  logic [15:0] ardata = '0;
  logic        rdv = 1'b0, waitreq = 1'b0;
  logic        busy, terr;

  int checks = 0, failures = 0, excl = 0;

  // Model state
  bit          m_en;
  bit          m_valid = 0;
  logic [31:0] m_tag = '0;
  logic [15:0] m_data = '0;
  bit          m_err = 0;

  always #5 clk = ~clk;

  dijkstra_mem_bridge #(
    .MADDR_WIDTH(32), .MDATA_WIDTH(16), .TIMEOUT_WIDTH(4)
  ) dut (
    .algorithm_clock(clk), .algorithm_reset(rst_n),
    .core_read_enable(cre), .core_write_enable(cwe),
    .core_addr(caddr), .core_write_data(cwdata),
    .core_read_data(crdata), .core_read_ready(crrdy),
    .core_write_ready(cwrdy),
    .avm_address(aaddr), .avm_read(aread), .avm_write(awrite),
    .avm_writedata(awdata), .avm_readdata(ardata),
    .avm_readdatavalid(rdv), .avm_waitrequest(waitreq),
    .busy(busy), .timeout_error(terr), .clear_error(clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core read with an Avalon slave that stalls nw cycles and returns
  // data dly cycles after command acceptance.
  task automatic do_read(input logic [31:0] a, input int nw, input int dly,
                         input logic [15:0] d, output logic [15:0] got,
                         output int lat, output int rc, output int wc,
                         output int bad, output logic err,
                         output logic bs, output logic bs_after);
    int wdone = 0, gap = 0;
    bit acc = 0;
    cre = 1'b1; caddr = a; waitreq = 1'b0; rdv = 1'b0;
    lat = -1; rc = 0; wc = 0; bad = 0; got = 'x; err = 'x; bs = 'x;
    for (int t = 1; t <= 40; t++) begin
      @(posedge clk); @(negedge clk);
      if (aread && awrite) excl++;
      if (crrdy) begin
        lat = t; got = crdata; err = terr; bs = busy;
        cre = 1'b0; rdv = 1'b0; waitreq = 1'b0;
        break;
      end
      if (aread) begin
        rc++;
        if (aaddr !== a) bad++;
      end
      if (awrite) wc++;
      if (aread) begin
        waitreq = (wdone < nw);
        if (waitreq) wdone++; else acc = 1;
        rdv = 1'($urandom_range(0, 1));
        ardata = 16'($urandom);
      end else if (acc) begin
        rdv = (gap == dly);
        ardata = rdv ? d : 16'($urandom);
        gap++;
      end else begin
        rdv = 1'b0; waitreq = 1'b0;
      end
    end
    cre = 1'b0; rdv = 1'b0; waitreq = 1'b0;
    @(posedge clk); @(negedge clk);
    bs_after = busy;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [15:0] d,
                          input int nw, output int lat, output int rc,
                          output int wc, output int bad, output logic err,
                          output logic bs, output logic bs_after);
    int wdone = 0;
    cwe = 1'b1; caddr = a; cwdata = d; waitreq = 1'b0; rdv = 1'b0;
    lat = -1; rc = 0; wc = 0; bad = 0; err = 'x; bs = 'x;
    for (int t = 1; t <= 40; t++) begin
      @(posedge clk); @(negedge clk);
      if (aread && awrite) excl++;
      if (cwrdy) begin
        lat = t; err = terr; bs = busy;
        cwe = 1'b0; waitreq = 1'b0;
        break;
      end
      if (aread) rc++;
      if (awrite) begin
        wc++;
        if (aaddr !== a || awdata !== d) bad++;
        waitreq = (wdone < nw);
        if (waitreq) wdone++;
      end
      rdv = 1'($urandom_range(0, 1));
      ardata = 16'($urandom);
    end
    cwe = 1'b0; rdv = 1'b0; waitreq = 1'b0;
    @(posedge clk); @(negedge clk);
    bs_after = busy;
  endtask

  task automatic run_rd(input string tag, input logic [31:0] a, input int nw,
                        input int dly, input logic [15:0] d);
    logic [15:0] e_got, got;
    int e_lat, e_rc, lat, rc, wc, bad;
    logic err, bs, bsa;
    if (m_en && m_valid && m_tag == a) begin
      e_got = m_data; e_lat = 1; e_rc = 0;
    end else if (nw >= 15) begin
      e_got = 16'hFFFF; e_lat = 16; e_rc = 15; m_valid = 0; m_err = 1;
    end else begin
      e_got = d; e_lat = nw + dly + 3; e_rc = nw + 1;
      m_valid = 1; m_tag = a; m_data = d;
    end
    do_read(a, nw, dly, d, got, lat, rc, wc, bad, err, bs, bsa);
    chk({tag, "_data"}, 32'(got), 32'(e_got));
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_avm_read_cyc"}, rc, e_rc);
    chk({tag, "_avm_write_cyc"}, wc, 0);
    chk({tag, "_addr"}, bad, 0);
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_busy_resp"}, 32'(bs), 1);
    chk({tag, "_busy_idle"}, 32'(bsa), 0);
  endtask

  task automatic run_wr(input string tag, input logic [31:0] a,
                        input logic [15:0] d, input int nw);
    int e_lat, e_wc, lat, rc, wc, bad;
    logic err, bs, bsa;
    if (m_valid && m_tag == a) m_data = d;
    if (nw >= 15) begin
      e_lat = 16; e_wc = 15; m_valid = 0; m_err = 1;
    end else begin
      e_lat = nw + 2; e_wc = nw + 1;
    end
    do_write(a, d, nw, lat, rc, wc, bad, err, bs, bsa);
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_avm_write_cyc"}, wc, e_wc);
    chk({tag, "_avm_read_cyc"}, rc, 0);
    chk({tag, "_addr_data"}, bad, 0);
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_busy_resp"}, 32'(bs), 1);
    chk({tag, "_busy_idle"}, 32'(bsa), 0);
  endtask

  initial begin
    logic [31:0] addrs [3];
    int pulses;
`ifdef DIJKSTRA_MEM_BRIDGE_HIT_CACHE_EN
    m_en = 1;
`else
    m_en = 0;
`endif
    addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h200;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rdata", 32'(crdata), 0);
    chk("rst_rrdy", 32'(crrdy), 0);
    chk("rst_wrdy", 32'(cwrdy), 0);
    chk("rst_aread", 32'(aread), 0);
    chk("rst_awrite", 32'(awrite), 0);
    chk("rst_aaddr", aaddr, 0);
    chk("rst_awdata", 32'(awdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_terr", 32'(terr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic read and stalled write
    run_rd("rd_0x100", 32'h100, 0, 0, 16'h1234);
    run_wr("wr_0x200", 32'h200, 16'hBEEF, 3);

    // Simultaneous read and write: read first, write afterwards
    cwe = 1'b1; cwdata = 16'h7777;
    run_rd("both_rd", 32'h300, 1, 1, 16'h4321);
    run_wr("both_wr", 32'h300, 16'h7777, 0);

    // Repeat read, write-through, read back
    run_rd("rd2_0x100", 32'h100, 0, 0, 16'h2222);
    run_wr("wr_0x100", 32'h100, 16'h5555, 0);
    run_rd("rd3_0x100", 32'h100, 0, 2, 16'hAAAA);

    // Random traffic
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      a = addrs[$urandom_range(0, 2)];
      if ($urandom_range(0, 1) == 1)
        run_rd("rnd_rd", a, $urandom_range(0, 3), $urandom_range(0, 3),
               16'($urandom));
      else
        run_wr("rnd_wr", a, 16'($urandom), $urandom_range(0, 3));
    end

    // Read timeout, then clear
    run_rd("tmo_rd", 32'h100, 100, 0, 16'h0);
    chk("tmo_sticky", 32'(terr), 1);
    clr = 1'b1; @(posedge clk); @(negedge clk); clr = 1'b0;
    m_err = 0;
    chk("clear_err", 32'(terr), 0);
    run_rd("after_tmo_rd", 32'h100, 0, 0, 16'h3333);

    // Timeout set wins over a concurrent clear
    clr = 1'b1;
    run_rd("tmo_setwins", 32'h104, 100, 0, 16'h0);
    clr = 1'b0; m_err = 0;
    chk("setwins_cleared", 32'(terr), 0);

    // Write timeout
    run_wr("tmo_wr", 32'h200, 16'h1111, 100);
    clr = 1'b1; @(posedge clk); @(negedge clk); clr = 1'b0;
    m_err = 0;

    // Reset during RD_DATA, then stray readdatavalid
    cre = 1'b1; caddr = 32'h400; waitreq = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    cre = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_aread", 32'(aread), 0);
    chk("midrst_aaddr", aaddr, 0);
    chk("midrst_rdata", 32'(crdata), 0);
    chk("midrst_rrdy", 32'(crrdy), 0);
    m_valid = 0; m_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    rdv = 1'b1; ardata = 16'h9999;
    pulses = 0;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); @(negedge clk);
      rdv = 1'b0;
      if (crrdy || cwrdy) pulses++;
    end
    chk("stray_pulses", pulses, 0);
    chk("stray_rdata", 32'(crdata), 0);
    chk("stray_busy", 32'(busy), 0);
    run_rd("post_rst_rd", 32'h100, 0, 0, 16'h6666);

    chk("rd_wr_exclusive", excl, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
